// File: rtl/timer_pkg.sv
// Shared constants for the APB timer counting stage and its register block.
package timer_pkg;

  // Counter/compare/load width shared with the register block.
  localparam int TIMER_WIDTH = 32;

  // Encoding of the cnt_dir control bit.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/timer_counter_if.sv
// Control/status bundle between the APB register block (master) and the
// timer counting stage (slave). clk and rst are kept as plain ports.
interface timer_counter_if #(
  parameter int WIDTH = timer_pkg::TIMER_WIDTH
);

  logic             clk_div;
  logic             div_en;
  logic             timer_en;
  logic             halt;
  logic             cnt_dir;
  logic             cnt_wr;
  logic [WIDTH-1:0] cnt_wdata;
  logic [WIDTH-1:0] cmp_val;
  logic             int_en;
  logic             int_clr;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt;
  logic             int_sts;
  logic             ovf_sts;
  logic             irq;

  // Register-block side: drives controls, observes count and status.
  modport master (
    output clk_div, div_en, timer_en, halt, cnt_dir, cnt_wr, cnt_wdata,
    output cmp_val, int_en, int_clr, ovf_clr,
    input  cnt, int_sts, ovf_sts, irq
  );

  // Timer side.
  modport slave (
    input  clk_div, div_en, timer_en, halt, cnt_dir, cnt_wr, cnt_wdata,
    input  cmp_val, int_en, int_clr, ovf_clr,
    output cnt, int_sts, ovf_sts, irq
  );

endinterface

// File: rtl/timer_counter_tick_gen.sv
// Tick generator: rising-edge detector on the prescaler output with a
// bypass that ticks every cycle. Kept separate so a capture channel can reuse it.
module tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic clk_div,
  input  logic div_en,
  output logic tick
);

  logic clk_div_q, clk_div_d;
  logic primed_q, primed_d;

  // Next-state: sample clk_div every cycle; primed goes high one cycle after reset.
  always_comb begin
    clk_div_d = clk_div;
    primed_d  = 1'b1;
  end

  // History flops; both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q <= 1'b0;
      primed_q  <= 1'b0;
    end else begin
      clk_div_q <= clk_div_d;
      primed_q  <= primed_d;
    end
  end

  // The history flop is forced low in reset, so in the first cycle after release
  // it cannot tell a genuine edge from a level that was already high. That cycle
  // is masked, which means a clk_div held high through reset does not tick.
  always_comb begin
    tick = 1'b1;
    if (div_en) begin
      tick = clk_div & ~clk_div_q & primed_q;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Timer counting stage: counts prescaler ticks in a loadable up/down counter,
// raises sticky compare-match and overflow status and a maskable irq.
// Optional macro TIMER_AUTO_RELOAD_EN selects periodic (auto-reload) mode.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  timer_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick;
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             int_sts_q, int_sts_d;
  logic             ovf_sts_q, ovf_sts_d;
  logic             irq_q, irq_d;

  tick_gen u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clk_div (bus.clk_div),
    .div_en  (bus.div_en),
    .tick    (tick)
  );

  // Counter, status and irq next-state; load beats step, step beats hold.
  always_comb begin
    step      = bus.timer_en & ~bus.halt & tick;
    cnt_d     = cnt_q;
    int_sts_d = int_sts_q & ~bus.int_clr;
    ovf_sts_d = ovf_sts_q & ~bus.ovf_clr;
    if (bus.cnt_dir == DIR_DOWN) begin
      cnt_nxt = cnt_q - ONE;
      wrap    = (cnt_q == '0);
    end else begin
      cnt_nxt = cnt_q + ONE;
      wrap    = (cnt_q == '1);
    end

    if (bus.cnt_wr) begin
      // A load never evaluates match or overflow.
      cnt_d = bus.cnt_wdata;
    end else if (step) begin
      cnt_d = cnt_nxt;
      // Match only on a step, so a static count or a cmp_val rewrite never fires.
      if (cnt_nxt == bus.cmp_val) begin
        int_sts_d = 1'b1;
      end
      if (wrap) begin
        ovf_sts_d = 1'b1;
      end
`ifdef TIMER_AUTO_RELOAD_EN
      if (bus.cnt_dir == DIR_UP && cnt_nxt == bus.cmp_val) begin
        cnt_d = '0;
      end else if (bus.cnt_dir == DIR_DOWN && wrap) begin
        cnt_d = bus.cmp_val;
      end
`endif
    end

    irq_d = bus.int_en & (int_sts_q | ovf_sts_q);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      int_sts_q <= 1'b0;
      ovf_sts_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      int_sts_q <= int_sts_d;
      ovf_sts_q <= ovf_sts_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.int_sts = int_sts_q;
  assign bus.ovf_sts = ovf_sts_q;
  assign bus.irq     = irq_q;

endmodule
